// File: rtl/writeback_queue.sv
// Dual-pipe writeback queue: one circular FIFO per exec pipe feeding the
// register unit. Heads pop into registered outputs every cycle; when both
// heads target the same register, pipe A goes first and pipe B waits a cycle.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   wbA_i,
    input  logic [4:0]             wbAddrA_i,
    input  logic [15:0]            wbValA_i,
    input  logic [1:0]             operationStatusA_i,
    input  logic                   wbB_i,
    input  logic [4:0]             wbAddrB_i,
    input  logic [15:0]            wbValB_i,
    input  logic [1:0]             operationStatusB_i,
    input  logic                   flushBack_i,
    output logic                   wbA_o,
    output logic [4:0]             wbAddrA_o,
    output logic [15:0]            wbValA_o,
    output logic [1:0]             operationStatusA_o,
    output logic                   wbB_o,
    output logic [4:0]             wbAddrB_o,
    output logic [15:0]            wbValB_o,
    output logic [1:0]             operationStatusB_o,
    output logic                   fullA_o,
    output logic                   fullB_o,
    output logic [$clog2(DEPTH):0] countA_o,
    output logic [$clog2(DEPTH):0] countB_o,
    output logic                   overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] val;
        logic [1:0]  status;
    } entry_t;

    entry_t        mem_a [DEPTH];
    entry_t        mem_b [DEPTH];
    logic [AW-1:0] rd_ptr_a, wr_ptr_a, rd_ptr_b, wr_ptr_b;
    logic [CW-1:0] count_a, count_b, count_a_next, count_b_next;
    entry_t        head_a, head_b, in_a, in_b;
    logic          valid_a, valid_b;
    logic          pop_a, pop_b, push_a, push_b, drop_a, drop_b;

    assign in_a   = '{addr: wbAddrA_i, val: wbValA_i, status: operationStatusA_i};
    assign in_b   = '{addr: wbAddrB_i, val: wbValB_i, status: operationStatusB_i};
    assign head_a = mem_a[rd_ptr_a];
    assign head_b = mem_b[rd_ptr_b];

    assign countA_o = count_a;
    assign countB_o = count_b;

    // Pop/push decisions and next occupancy; all derived from registered
    // state plus this cycle's requests, so nothing reaches the outputs
    // without passing through a flop.
    always_comb begin
        valid_a = (count_a != '0);
        valid_b = (count_b != '0);
        pop_a   = valid_a;
        // B yields to A when both heads would write the same register.
        pop_b   = valid_b && !(valid_a && (head_a.addr == head_b.addr));
        // A full FIFO still accepts a push when its head leaves on this edge.
        push_a  = wbA_i && ((count_a != FULL_CNT) || pop_a);
        push_b  = wbB_i && ((count_b != FULL_CNT) || pop_b);
        drop_a  = wbA_i && !push_a;
        drop_b  = wbB_i && !push_b;

        count_a_next = count_a;
        if (push_a && !pop_a) begin
            count_a_next = count_a + CW'(1);
        end else if (!push_a && pop_a) begin
            count_a_next = count_a - CW'(1);
        end

        count_b_next = count_b;
        if (push_b && !pop_b) begin
            count_b_next = count_b + CW'(1);
        end else if (!push_b && pop_b) begin
            count_b_next = count_b - CW'(1);
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !flushBack_i) begin
            if (push_a) begin
                mem_a[wr_ptr_a] <= in_a;
            end
            if (push_b) begin
                mem_b[wr_ptr_b] <= in_b;
            end
        end
    end

    // Pointers, occupancy and full flags; flush empties both pipes at once.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_a <= '0;
            wr_ptr_a <= '0;
            rd_ptr_b <= '0;
            wr_ptr_b <= '0;
            count_a  <= '0;
            count_b  <= '0;
            fullA_o  <= 1'b0;
            fullB_o  <= 1'b0;
        end else if (flushBack_i) begin
            rd_ptr_a <= '0;
            wr_ptr_a <= '0;
            rd_ptr_b <= '0;
            wr_ptr_b <= '0;
            count_a  <= '0;
            count_b  <= '0;
            fullA_o  <= 1'b0;
            fullB_o  <= 1'b0;
        end else begin
            if (push_a) begin
                wr_ptr_a <= wr_ptr_a + AW'(1);
            end
            if (pop_a) begin
                rd_ptr_a <= rd_ptr_a + AW'(1);
            end
            if (push_b) begin
                wr_ptr_b <= wr_ptr_b + AW'(1);
            end
            if (pop_b) begin
                rd_ptr_b <= rd_ptr_b + AW'(1);
            end
            count_a <= count_a_next;
            count_b <= count_b_next;
            fullA_o <= (count_a_next == FULL_CNT);
            fullB_o <= (count_b_next == FULL_CNT);
        end
    end

    // Register-unit write port: strobe on pop, payload holds when idle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wbA_o              <= 1'b0;
            wbAddrA_o          <= '0;
            wbValA_o           <= '0;
            operationStatusA_o <= '0;
            wbB_o              <= 1'b0;
            wbAddrB_o          <= '0;
            wbValB_o           <= '0;
            operationStatusB_o <= '0;
        end else if (flushBack_i) begin
            wbA_o <= 1'b0;
            wbB_o <= 1'b0;
        end else begin
            wbA_o <= pop_a;
            if (pop_a) begin
                wbAddrA_o          <= head_a.addr;
                wbValA_o           <= head_a.val;
                operationStatusA_o <= head_a.status;
            end
            wbB_o <= pop_b;
            if (pop_b) begin
                wbAddrB_o          <= head_b.addr;
                wbValB_o           <= head_b.val;
                operationStatusB_o <= head_b.status;
            end
        end
    end

    // Sticky drop indicator; a flushed push is discarded, not dropped.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
        end else if (!flushBack_i && (drop_a || drop_b)) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with per-pipe expected-output queues.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbA_i, wbB_i, flush;
    logic [4:0]  addrA_i, addrB_i;
    logic [15:0] valA_i, valB_i;
    logic [1:0]  stA_i, stB_i;
    logic        wbA_o, wbB_o, fullA_o, fullB_o, overflow_o;
    logic [4:0]  addrA_o, addrB_o;
    logic [15:0] valA_o, valB_o;
    logic [1:0]  stA_o, stB_o;
    logic [2:0]  countA_o, countB_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [22:0] qa[$];
    logic [22:0] qb[$];

    writeback_queue #(.DEPTH(4)) dut (
        .clock_i(clk), .reset_i(rst),
        .wbA_i(wbA_i), .wbAddrA_i(addrA_i), .wbValA_i(valA_i), .operationStatusA_i(stA_i),
        .wbB_i(wbB_i), .wbAddrB_i(addrB_i), .wbValB_i(valB_i), .operationStatusB_i(stB_i),
        .flushBack_i(flush),
        .wbA_o(wbA_o), .wbAddrA_o(addrA_o), .wbValA_o(valA_o), .operationStatusA_o(stA_o),
        .wbB_o(wbB_o), .wbAddrB_o(addrB_o), .wbValB_o(valB_o), .operationStatusB_o(stB_o),
        .fullA_o(fullA_o), .fullB_o(fullB_o),
        .countA_o(countA_o), .countB_o(countB_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare any write-port activity with the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        if (wbA_o === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++;
                assert (qa.size() != 0) else begin
                    n_err++;
                    $error("FAIL a_extra: observed 0x%0h expected none", {addrA_o, valA_o, stA_o});
                end
            end else begin
                chk("a_data", 32'({addrA_o, valA_o, stA_o}), 32'(qa.pop_front()));
            end
        end
        if (wbB_o === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++;
                assert (qb.size() != 0) else begin
                    n_err++;
                    $error("FAIL b_extra: observed 0x%0h expected none", {addrB_o, valB_o, stB_o});
                end
            end else begin
                chk("b_data", 32'({addrB_o, valB_o, stB_o}), 32'(qb.pop_front()));
            end
        end
    endtask

    task automatic set_a(input logic en, input logic [4:0] a, input logic [15:0] v,
                         input logic [1:0] s, input logic expect_out);
        wbA_i = en; addrA_i = a; valA_i = v; stA_i = s;
        if (expect_out) qa.push_back({a, v, s});
    endtask

    task automatic set_b(input logic en, input logic [4:0] a, input logic [15:0] v,
                         input logic [1:0] s, input logic expect_out);
        wbB_i = en; addrB_i = a; valB_i = v; stB_i = s;
        if (expect_out) qb.push_back({a, v, s});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        #12;
        chk("rst_wbA", 32'(wbA_o), 32'(0));
        chk("rst_wbB", 32'(wbB_o), 32'(0));
        chk("rst_countA", 32'(countA_o), 32'(0));
        chk("rst_fullB", 32'(fullB_o), 32'(0));
        chk("rst_overflow", 32'(overflow_o), 32'(0));
        chk("rst_valA", 32'(valA_o), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        step();

        // single push, one-cycle latency, no forwarding
        set_a(1, 5'd3, 16'h1234, 2'b01, 1);
        step();
        set_a(0, 0, 0, 0, 0);
        chk("single_no_fwd", 32'(wbA_o), 32'(0));
        chk("single_countA", 32'(countA_o), 32'(1));
        step();
        chk("single_strobe", 32'(wbA_o), 32'(1));
        chk("single_count0", 32'(countA_o), 32'(0));
        step();
        chk("single_gap", 32'(wbA_o), 32'(0));

        // ordered burst on A
        for (int i = 0; i < 6; i++) begin
            set_a(1, 5'(i), 16'(16'hA0 + i), 2'(i), 1);
            step();
            chk("burst_fullA", 32'(fullA_o), 32'(0));
            chk("burst_countA", 32'(countA_o), 32'(1));
        end
        set_a(0, 0, 0, 0, 0);
        step();
        step();
        chk("burst_overflow", 32'(overflow_o), 32'(0));
        chk("burst_drained", 32'(qa.size()), 32'(0));

        // same-address conflict
        set_a(1, 5'd7, 16'h0001, 2'b00, 1);
        set_b(1, 5'd7, 16'h0002, 2'b00, 1);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        chk("conflict_a_go", 32'(wbA_o), 32'(1));
        chk("conflict_b_hold", 32'(wbB_o), 32'(0));
        step();
        chk("conflict_b_go", 32'(wbB_o), 32'(1));
        chk("conflict_a_idle", 32'(wbA_o), 32'(0));
        step();

        // B backlog through repeated conflicts, then a dropped push
        for (int k = 0; k < 4; k++) begin
            set_a(1, 5'd7, 16'(16'h100 + k), 2'b10, 1);
            set_b(1, 5'd7, 16'(16'h200 + k), 2'b01, 1);
            step();
            chk("backlog_b_hold", 32'(wbB_o), 32'(0));
            chk("backlog_countB", 32'(countB_o), 32'(k + 1));
        end
        chk("backlog_fullB", 32'(fullB_o), 32'(1));
        chk("backlog_no_ovf", 32'(overflow_o), 32'(0));
        set_a(1, 5'd7, 16'h0104, 2'b10, 1);
        set_b(1, 5'd7, 16'h02FF, 2'b11, 0);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        chk("drop_overflow", 32'(overflow_o), 32'(1));
        chk("drop_countB", 32'(countB_o), 32'(4));
        chk("drop_fullB", 32'(fullB_o), 32'(1));
        step();
        chk("drain_b_hold", 32'(wbB_o), 32'(0));
        for (int k = 0; k < 5; k++) step();
        chk("drain_qb", 32'(qb.size()), 32'(0));
        chk("drain_countB", 32'(countB_o), 32'(0));
        chk("drain_ovf_sticky", 32'(overflow_o), 32'(1));

        // flush with queued entries in both pipes and a push in flight
        for (int k = 0; k < 3; k++) begin
            set_a(1, 5'd9, 16'(16'h61 + k), 2'b00, k < 2);
            set_b(1, 5'd9, 16'(16'h71 + k), 2'b00, 0);
            step();
        end
        chk("preflush_countB", 32'(countB_o), 32'(3));
        set_a(1, 5'd9, 16'h0064, 2'b00, 0);
        set_b(1, 5'd9, 16'h0074, 2'b00, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        chk("flush_wbA", 32'(wbA_o), 32'(0));
        chk("flush_wbB", 32'(wbB_o), 32'(0));
        chk("flush_countA", 32'(countA_o), 32'(0));
        chk("flush_countB", 32'(countB_o), 32'(0));
        chk("flush_ovf_kept", 32'(overflow_o), 32'(1));
        for (int k = 0; k < 3; k++) step();
        chk("flush_qa", 32'(qa.size()), 32'(0));

        // asynchronous reset between edges with entries queued
        set_a(1, 5'd4, 16'h0081, 2'b01, 1);
        set_b(1, 5'd4, 16'h0091, 2'b01, 0);
        step();
        set_a(1, 5'd4, 16'h0082, 2'b01, 0);
        set_b(1, 5'd4, 16'h0092, 2'b01, 0);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        chk("pre_rst_wbA", 32'(wbA_o), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wbA", 32'(wbA_o), 32'(0));
        chk("arst_valA", 32'(valA_o), 32'(0));
        chk("arst_addrA", 32'(addrA_o), 32'(0));
        chk("arst_countA", 32'(countA_o), 32'(0));
        chk("arst_countB", 32'(countB_o), 32'(0));
        chk("arst_overflow", 32'(overflow_o), 32'(0));
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        step();
        set_a(1, 5'd5, 16'h00C0, 2'b11, 1);
        step();
        set_a(0, 0, 0, 0, 0);
        chk("post_rst_no_fwd", 32'(wbA_o), 32'(0));
        chk("post_rst_countA", 32'(countA_o), 32'(1));
        step();
        chk("post_rst_strobe", 32'(wbA_o), 32'(1));
        chk("post_rst_wbB", 32'(wbB_o), 32'(0));
        step();

        chk("final_qa", 32'(qa.size()), 32'(0));
        chk("final_qb", 32'(qb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, default 4, entries per pipe FIFO; power of two, minimum 2.
REQ-002 clock_i  input  1  single clock; all state changes on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 wbA_i / wbB_i  input  1 each  pipe A / pipe B exec result valid, request to write back.
REQ-005 wbAddrA_i / wbAddrB_i  input  5 each  destination register address.
REQ-006 wbValA_i / wbValB_i  input  16 each  result value.
REQ-007 operationStatusA_i / operationStatusB_i  input  2 each  bit 1 overflow, bit 0 underflow.
REQ-008 flushBack_i  input  1  discard all queued and incoming results.
REQ-009 wbA_o / wbB_o  output  1 each  register-unit write strobe for pipe A / pipe B.
REQ-010 wbAddrA_o / wbAddrB_o  output  5 each  register-unit write address.
REQ-011 wbValA_o / wbValB_o  output  16 each  register-unit write value.
REQ-012 operationStatusA_o / operationStatusB_o  output  2 each  status travelling with the entry.
REQ-013 fullA_o / fullB_o  output  1 each  FIFO holds DEPTH entries; exec pipe must stall.
REQ-014 countA_o / countB_o  output  log2(DEPTH)+1 each  current occupancy.
REQ-015 overflow_o  output  1  sticky: a push was dropped.

Function
REQ-016 Each pipe SHALL own an independent circular FIFO of DEPTH entries; each entry holds {addr[4:0], val[15:0], status[1:0]}; read/write pointers wrap modulo DEPTH.
REQ-017 Push: wbX_i=1 at edge N with count<DEPTH, or with count=DEPTH and a pop at the same edge; the entry is written at the tail.
REQ-018 Push with wbX_i=1, count=DEPTH, and no pop at that edge SHALL drop the entry, leave the FIFO unchanged, and set overflow_o=1 from edge N+1 until reset.
REQ-019 Pop: at every edge, a non-empty FIFO SHALL pop its head into the registered outputs, with wbX_o=1, addr/val/status=head; an empty FIFO drives wbX_o=0 and holds addr/val/status.
REQ-020 Latency: an entry pushed into an empty FIFO at edge N SHALL appear on the outputs after edge N+1 and SHALL NOT be forwarded in the same cycle.
REQ-021 Order: entries within a pipe SHALL leave in push order; no ordering between pipes except REQ-022.
REQ-022 Conflict: if both heads are valid at an edge and their addresses are equal, A pops, B holds its head (wbB_o=0 that cycle), and B pops at the next edge.
REQ-023 count SHALL update as count + push - pop and never exceed DEPTH or go below 0; fullX_o = (count==DEPTH) and countX_o = count, both registered.
REQ-024 Flush: flushBack_i=1 at edge N SHALL reset both pointers and both counts to 0, drive wbA_o=wbB_o=0 after edge N, and discard any push presented at edge N; overflow_o is unaffected.
REQ-025 Flush has priority over push, pop, and conflict hold.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 While reset_i=1, asynchronously:
- pointers=0, counts=0
- wbA_o=wbB_o=0
- wbAddrX_o=0, wbValX_o=0, operationStatusX_o=0
- fullX_o=0, countX_o=0, overflow_o=0
REQ-028 Entry storage need not be cleared.
REQ-029 Reset asserted mid-operation SHALL abandon all queued entries; the first push after deassertion behaves as a push into an empty queue.

Verification
REQ-030 Single push: wbA_i=1, addr=3, val=0x1234, status=2'b01 for one cycle. Next cycle: wbA_o=1, wbAddrA_o=3, wbValA_o=0x1234, operationStatusA_o=01. Following cycle: wbA_o=0.
REQ-031 Ordered burst: with DEPTH=4, push A entries 0xA0..0xA5 on consecutive cycles. Outputs show 0xA0..0xA5 in order on consecutive cycles; fullA_o never asserts; overflow_o=0.
REQ-032 Conflict: wbA_i=wbB_i=1, both addr=7, A val 0x0001, B val 0x0002. Next cycle: A writes 0x0001 with wbB_o=0. Cycle after: wbB_o=1 with 0x0002.
REQ-033 Full/overflow: force a B backlog using repeated same-address conflicts until countB_o=4, fullB_o=1. Then push B with no pop: entry dropped, overflow_o=1, countB_o stays 4.
REQ-034 Flush: queue 3 entries in A, then flushBack_i=1 together with wbA_i=1. Next cycle: wbA_o=0, countA_o=0; no discarded value ever appears.
REQ-035 Async reset: assert reset_i between clock edges while entries are queued. Outputs go to 0 immediately, without waiting for a clock edge.
